cache_stage_pipe: RTL and testbench

- Parametrised request stage register for the pipelined cache. Sits between the request-accept stage and the tag/data-array stage.
- Carries addr/rmask/wmask/wdata with a valid/ready handshake, stall hold, flush, and normalisation of malformed masks.
- Drives the active-low SRAM chip select from stage occupancy, not from the controller state.
- Optional 2-entry skid buffer registers up_ready.

---
 rtl/cache_pipe_pkg.sv | 33 +++
 rtl/cache_req_slot.sv | 42 ++++
 rtl/cache_stage_pipe.sv | 155 +++++++++++++++
 tb/tb_cache_stage_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pipe_pkg.sv
// rtl/cache_pipe_pkg.sv - shared request type and mask normalisation for the cache request stage
package cache_pipe_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_MASK_W = REQ_DATA_W / 8;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_MASK_W-1:0] rmask;
        logic [REQ_MASK_W-1:0] wmask;
        logic [REQ_DATA_W-1:0] wdata;
    } cache_req_t;

    typedef struct packed {
        logic       keep;
        cache_req_t req;
        logic       err;
    } cache_norm_t;

    // Empty masks are dropped; read+write collapses to a write and flags an error.
    function automatic cache_norm_t normalize_req(input cache_req_t r);
        cache_norm_t n;
        n.req  = r;
        n.keep = (|r.rmask) | (|r.wmask);
        n.err  = (|r.rmask) & (|r.wmask);
        if (n.err) begin
            n.req.rmask = '0;
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_req_slot.sv
// rtl/cache_req_slot.sv - one valid+payload holding register with load, clear and sync reset
module cache_req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // Load wins over clear so a slot can be popped and refilled in one cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/cache_stage_pipe.sv
// rtl/cache_stage_pipe.sv - request stage register between accept and tag/data-array stages
// Optional skid slot with registered up_ready when CACHE_STAGE_SKID_EN is defined.
module cache_stage_pipe
    import cache_pipe_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [ADDR_W-1:0]      up_addr,
    input  logic [DATA_W/8-1:0]    up_rmask,
    input  logic [DATA_W/8-1:0]    up_wmask,
    input  logic [DATA_W-1:0]      up_wdata,
    output logic                   dn_valid,
    input  logic                   dn_ready,
    output logic [ADDR_W-1:0]      dn_addr,
    output logic [DATA_W/8-1:0]    dn_rmask,
    output logic [DATA_W/8-1:0]    dn_wmask,
    output logic [DATA_W-1:0]      dn_wdata,
    output logic                   dn_csb,
    output logic [1:0]             occupancy,
    output logic                   mask_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PAY_W  = ADDR_W + 2 * MASK_W + DATA_W;

    logic [PAY_W-1:0] up_payload;
    logic             up_keep;
    logic             up_err;

    if (ADDR_W == REQ_ADDR_W && DATA_W == REQ_DATA_W) begin : g_norm_pkg
        cache_req_t  up_req;
        cache_norm_t up_norm;
        always_comb begin
            up_req     = '{addr: up_addr, rmask: up_rmask, wmask: up_wmask, wdata: up_wdata};
            up_norm    = normalize_req(up_req);
            up_keep    = up_norm.keep;
            up_err     = up_norm.err;
            up_payload = up_norm.req;
        end
    end else begin : g_norm_wide
        // Same rule as normalize_req, for widths the shared struct does not cover.
        always_comb begin
            up_keep    = (|up_rmask) | (|up_wmask);
            up_err     = (|up_rmask) & (|up_wmask);
            up_payload = {up_addr, (up_err ? {MASK_W{1'b0}} : up_rmask), up_wmask, up_wdata};
        end
    end

    logic             main_v, main_load, main_clear;
    logic [PAY_W-1:0] main_d, main_q;
    logic             up_fire, in_fire, dn_fire;

    assign dn_valid = main_v;
    assign dn_fire  = main_v && dn_ready;
    assign up_fire  = up_valid && up_ready;
    assign in_fire  = up_fire && up_keep;

`ifdef CACHE_STAGE_SKID_EN
    logic             skid_v, skid_load, skid_clear;
    logic [PAY_W-1:0] skid_q;

    assign up_ready = !rst && !flush && !skid_v;

    // The skid slot only fills while main is full and stalled, so ordering is main then skid.
    always_comb begin
        main_load  = 1'b0;
        main_d     = up_payload;
        main_clear = dn_fire || flush;
        skid_load  = 1'b0;
        skid_clear = flush;
        if (!flush) begin
            if (skid_v && dn_fire) begin
                main_load  = 1'b1;
                main_d     = skid_q;
                skid_clear = 1'b1;
            end else if (in_fire && (!main_v || dn_fire)) begin
                main_load = 1'b1;
            end else if (in_fire) begin
                skid_load = 1'b1;
            end
        end
    end

    cache_req_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (up_payload),
        .valid (skid_v),
        .q     (skid_q)
    );

    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
    assign up_ready = !rst && !flush && (!main_v || dn_ready);

    always_comb begin
        main_load  = in_fire;
        main_d     = up_payload;
        main_clear = dn_fire || flush;
    end

    assign occupancy = {1'b0, main_v};
`endif

    cache_req_slot #(.W(PAY_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    assign dn_addr  = main_q[PAY_W-1 -: ADDR_W];
    assign dn_rmask = main_q[DATA_W + 2*MASK_W - 1 -: MASK_W];
    assign dn_wmask = main_q[DATA_W + MASK_W - 1 -: MASK_W];
    assign dn_wdata = main_q[DATA_W-1:0];
    assign dn_csb   = !main_v;

    logic                   mask_err_d, mask_err_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        mask_err_d  = mask_err_q | (up_fire && up_err);
        stall_cnt_d = stall_cnt_q;
        if (main_v && !dn_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_err_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            mask_err_q  <= mask_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mask_err  = mask_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cache_stage_pipe.sv
// tb/tb_cache_stage_pipe.sv - self-checking bench for cache_stage_pipe (vector table, directed, random vs queue model)
module tb_cache_stage_pipe;

`ifdef CACHE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, up_valid, up_ready, dn_valid, dn_ready, dn_csb, mask_err;
    logic [31:0]   up_addr, up_wdata, dn_addr, dn_wdata;
    logic [3:0]    up_rmask, up_wmask, dn_rmask, dn_wmask;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_stage_pipe #(.ADDR_W(32), .DATA_W(32), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr),
        .up_rmask(up_rmask), .up_wmask(up_wmask), .up_wdata(up_wdata),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_addr(dn_addr),
        .dn_rmask(dn_rmask), .dn_wmask(dn_wmask), .dn_wdata(dn_wdata),
        .dn_csb(dn_csb), .occupancy(occupancy), .mask_err(mask_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs half a cycle before the edge and sample 1 time unit later.
    task automatic cyc(input logic r, input logic f, input logic uv, input logic [31:0] a,
                       input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                       input logic dr);
        @(negedge clk);
        rst = r; flush = f; up_valid = uv; up_addr = a;
        up_rmask = rm; up_wmask = wm; up_wdata = wd; dn_ready = dr;
        #1;
    endtask

    typedef struct {
        logic        rst, uv, dr, chk_st, chk_pay;
        logic [31:0] addr, wd;
        logic [3:0]  rm, wm;
        logic        e_ur, e_dv, e_err;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_rm, e_wm;
        logic [1:0]  e_occ;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic uv, input logic [31:0] a,
                                input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                                input logic cs, input logic cp, input logic eur, input logic edv,
                                input logic [31:0] ea, input logic [3:0] erm, input logic [3:0] ewm,
                                input logic [31:0] ewd, input logic eerr);
        vec_t v;
        v.rst = r; v.uv = uv; v.dr = 1'b1; v.addr = a; v.rm = rm; v.wm = wm; v.wd = wd;
        v.chk_st = cs; v.chk_pay = cp; v.e_ur = eur; v.e_dv = edv; v.e_addr = ea;
        v.e_rm = erm; v.e_wm = ewm; v.e_wd = ewd; v.e_err = eerr;
        v.e_occ = {1'b0, edv};
        return v;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [3:0]  r, w;
        logic [31:0] d;
    } mreq_t;

    vec_t  tbl[11];
    mreq_t mq[$];
    mreq_t mr;
    bit    m_err;
    int    m_stall;

    initial begin
        tbl[0]  = mk(1, 1, 32'h100, 4'hF, 4'h0, 32'h0,   0, 0, 0, 0, 32'h0,   4'h0, 4'h0, 32'h0, 0);
        tbl[1]  = mk(1, 1, 32'h100, 4'hF, 4'h0, 32'h0,   1, 1, 0, 0, 32'h0,   4'h0, 4'h0, 32'h0, 0);
        tbl[2]  = mk(0, 1, 32'h100, 4'hF, 4'h0, 32'h11,  1, 1, 1, 0, 32'h0,   4'h0, 4'h0, 32'h0, 0);
        tbl[3]  = mk(0, 1, 32'h104, 4'hF, 4'h0, 32'h22,  1, 1, 1, 1, 32'h100, 4'hF, 4'h0, 32'h11, 0);
        tbl[4]  = mk(0, 1, 32'h108, 4'hF, 4'h0, 32'h33,  1, 1, 1, 1, 32'h104, 4'hF, 4'h0, 32'h22, 0);
        tbl[5]  = mk(0, 1, 32'h1F0, 4'h0, 4'h0, 32'h44,  1, 1, 1, 1, 32'h108, 4'hF, 4'h0, 32'h33, 0);
        tbl[6]  = mk(0, 0, 32'h0,   4'h0, 4'h0, 32'h0,   1, 0, 1, 0, 32'h0,   4'h0, 4'h0, 32'h0, 0);
        tbl[7]  = mk(0, 1, 32'h300, 4'hF, 4'h3, 32'hDEADBEEF, 1, 0, 1, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        tbl[8]  = mk(0, 1, 32'h304, 4'h1, 4'h0, 32'h55,  1, 1, 1, 1, 32'h300, 4'h0, 4'h3, 32'hDEADBEEF, 1);
        tbl[9]  = mk(0, 0, 32'h0,   4'h0, 4'h0, 32'h0,   1, 1, 1, 1, 32'h304, 4'h1, 4'h0, 32'h55, 1);
        tbl[10] = mk(0, 0, 32'h0,   4'h0, 4'h0, 32'h0,   1, 0, 1, 0, 32'h0,   4'h0, 4'h0, 32'h0, 1);

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, 1'b0, tbl[i].uv, tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].wd, tbl[i].dr);
            chk($sformatf("tbl%0d up_ready", i), up_ready, tbl[i].e_ur);
            if (tbl[i].chk_st) begin
                chk($sformatf("tbl%0d dn_valid", i), dn_valid, tbl[i].e_dv);
                chk($sformatf("tbl%0d dn_csb", i), dn_csb, !tbl[i].e_dv);
                chk($sformatf("tbl%0d occupancy", i), occupancy, tbl[i].e_occ);
                chk($sformatf("tbl%0d mask_err", i), mask_err, tbl[i].e_err);
                chk($sformatf("tbl%0d stall_cnt", i), stall_cnt, 0);
            end
            if (tbl[i].chk_pay) begin
                chk($sformatf("tbl%0d dn_addr", i), dn_addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d dn_rmask", i), dn_rmask, tbl[i].e_rm);
                chk($sformatf("tbl%0d dn_wmask", i), dn_wmask, tbl[i].e_wm);
                chk($sformatf("tbl%0d dn_wdata", i), dn_wdata, tbl[i].e_wd);
            end
        end

        // Stall with a second request offered, then release.
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h200, 4'hF, 4'h0, 32'hA0, 0);
        chk("stall first up_ready", up_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 1, 32'h204, 4'hF, 4'h0, 32'hA4, 0);
            chk($sformatf("stall%0d dn_addr", k), dn_addr, 32'h200);
            chk($sformatf("stall%0d stall_cnt", k), stall_cnt, k - 1);
            if (k == 1) begin
                chk("stall1 up_ready", up_ready, SKID);
                chk("stall1 occupancy", occupancy, 1);
            end else begin
                chk($sformatf("stall%0d up_ready", k), up_ready, 0);
                chk($sformatf("stall%0d occupancy", k), occupancy, SKID ? 2 : 1);
            end
        end
        cyc(0, 0, 1, 32'h204, 4'hF, 4'h0, 32'hA4, 1);
        chk("release dn_addr", dn_addr, 32'h200);
        chk("release stall_cnt", stall_cnt, 5);
        chk("release up_ready", up_ready, !SKID);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("second dn_valid", dn_valid, 1);
        chk("second dn_addr", dn_addr, 32'h204);
        chk("second dn_wdata", dn_wdata, 32'hA4);
        chk("second up_ready", up_ready, 1);
        chk("second occupancy", occupancy, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("drained dn_valid", dn_valid, 0);
        chk("drained occupancy", occupancy, 0);

        // Flush with slots full and a request offered in the flush cycle.
        cyc(0, 0, 1, 32'h400, 4'hF, 4'h0, 32'hB0, 0);
        cyc(0, 0, 1, 32'h404, 4'hF, 4'h0, 32'hB4, 0);
        chk("pre-flush up_ready", up_ready, SKID);
        cyc(0, 1, 1, 32'h408, 4'hF, 4'h0, 32'hB8, 1);
        chk("flush up_ready", up_ready, 0);
        chk("flush occupancy", occupancy, SKID ? 2 : 1);
        chk("flush dn_addr", dn_addr, 32'h400);
        chk("flush stall_cnt", stall_cnt, 6);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post-flush dn_valid", dn_valid, 0);
        chk("post-flush dn_csb", dn_csb, 1);
        chk("post-flush occupancy", occupancy, 0);
        chk("post-flush stall_cnt", stall_cnt, 6);
        chk("post-flush up_ready", up_ready, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("post-flush2 dn_valid", dn_valid, 0);

        // Counter saturation.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h500, 4'h1, 4'h0, 32'hC0, 0);
        chk("sat start stall_cnt", stall_cnt, 0);
        chk("sat start mask_err", mask_err, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat stall_cnt", stall_cnt, 15);
        chk("sat dn_addr", dn_addr, 32'h500);

        // Random traffic against a FIFO-of-requests reference.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        mq.delete(); m_err = 0; m_stall = 0;
        for (int n = 0; n < 2000; n++) begin
            logic r, f, uv, dr, eur;
            logic [3:0] rm, wm;
            logic [31:0] a, wd;
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 15) == 0);
            uv = $urandom_range(0, 1);
            dr = ($urandom_range(0, 9) < 6);
            rm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a  = $urandom;
            wd = $urandom;
            cyc(r, f, uv, a, rm, wm, wd, dr);
            if (r || f) eur = 0;
            else if (SKID) eur = (mq.size() < 2);
            else eur = (mq.size() == 0) || dr;
            chk("rnd up_ready", up_ready, eur);
            chk("rnd dn_valid", dn_valid, mq.size() > 0);
            chk("rnd dn_csb", dn_csb, mq.size() == 0);
            chk("rnd occupancy", occupancy, mq.size());
            chk("rnd mask_err", mask_err, m_err);
            chk("rnd stall_cnt", stall_cnt, m_stall);
            if (mq.size() > 0) begin
                chk("rnd dn_addr", dn_addr, mq[0].a);
                chk("rnd dn_rmask", dn_rmask, mq[0].r);
                chk("rnd dn_wmask", dn_wmask, mq[0].w);
                chk("rnd dn_wdata", dn_wdata, mq[0].d);
            end
            if (r) begin
                mq.delete(); m_err = 0; m_stall = 0;
            end else begin
                if (mq.size() > 0 && !dr && m_stall < 15) m_stall++;
                if (mq.size() > 0 && dr) void'(mq.pop_front());
                if (f) mq.delete();
                else if (uv && eur && (rm != 0 || wm != 0)) begin
                    mr.a = a; mr.w = wm; mr.d = wd;
                    mr.r = (wm != 0) ? 4'h0 : rm;
                    mq.push_back(mr);
                    if (rm != 0 && wm != 0) m_err = 1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
